// File: rtl/player_pkg.sv
// Shared definitions for the player controller, collision and render blocks:
// default grid sizing, the bullet slot record and small helper functions.
package player_pkg;

  // Default grid sizing; blocks may override the widths through parameters.
  localparam int DEF_X_W         = 5;
  localparam int DEF_Y_W         = 4;
  localparam int DEF_NUM_BULLETS = 4;

  // Row Y_MAX is the ship row and doubles as the "no bullet" sentinel.
  localparam logic [DEF_X_W-1:0] DEF_X_MAX = '1;
  localparam logic [DEF_Y_W-1:0] DEF_Y_MAX = '1;

  // One bullet slot as seen by collision/render logic.
  typedef struct packed {
    logic               active;
    logic [DEF_X_W-1:0] x;
    logic [DEF_Y_W-1:0] y;
  } slot_t;

  // Resolved ship movement request for one cycle.
  typedef enum logic [1:0] {
    MOVE_HOLD  = 2'd0,
    MOVE_LEFT  = 2'd1,
    MOVE_RIGHT = 2'd2
  } move_e;

  // Left-only and right-only move; both or neither cancel out.
  function automatic move_e decode_move(input logic left, input logic right);
    if (left && !right) return MOVE_LEFT;
    if (right && !left) return MOVE_RIGHT;
    return MOVE_HOLD;
  endfunction

  // Counter width able to hold 0..cooldown, never narrower than one bit.
  function automatic int cd_width(input int cooldown);
    return (cooldown <= 1) ? 1 : $clog2(cooldown + 1);
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: load on fire, step up the screen on each tick, drop out
// when it leaves the top row or is hit. Priority: reset > hit > advance.
module bullet_slot #(
  parameter int X_W = 5,
  parameter int Y_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic           tick,
  input  logic           hit,
  output logic           active,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  localparam logic [Y_W-1:0] Y_MAX = '1;

  // Slot state: an inactive slot always parks at x=0, y=Y_MAX.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      x      <= '0;
      y      <= Y_MAX;
    end else if (active && hit) begin
      active <= 1'b0;
      x      <= '0;
      y      <= Y_MAX;
    end else if (active && tick) begin
      if (y == '0) begin
        active <= 1'b0;
        x      <= '0;
        y      <= Y_MAX;
      end else begin
        y <= y - Y_W'(1);
      end
    end else if (!active && load) begin
      // A fresh bullet is not advanced by a coincident tick.
      active <= 1'b1;
      x      <= load_x;
      y      <= Y_MAX - Y_W'(1);
    end
  end

endmodule

// File: rtl/player_multishot.sv
// Player controller: ship column, fire cooldown, lowest-free slot allocation
// and NUM_BULLETS bullet slots.
// Build option: define PLAYER_MULTISHOT_WRAP_EN to make the ship wrap around
// the screen edges instead of saturating.
module player_multishot
  import player_pkg::*;
#(
  parameter int X_W         = DEF_X_W,
  parameter int Y_W         = DEF_Y_W,
  parameter int NUM_BULLETS = DEF_NUM_BULLETS,
  parameter int COOLDOWN    = 2,
  parameter int SHIP_X_RST  = 16
) (
  input  logic                       i_clk_36MHz,
  input  logic                       i_reset,
  input  logic                       i_left,
  input  logic                       i_right,
  input  logic                       i_shoot,
  input  logic                       i_tick,
  input  logic [NUM_BULLETS-1:0]     i_hit,
  output logic [X_W-1:0]             o_ship_x,
  output logic [NUM_BULLETS-1:0]     o_bullet_active,
  output logic [NUM_BULLETS*X_W-1:0] o_bullet_x,
  output logic [NUM_BULLETS*Y_W-1:0] o_bullet_y,
  output logic                       o_fire_ready
);

  localparam int             CD_W  = cd_width(COOLDOWN);
  localparam logic [X_W-1:0] X_MAX = '1;

  logic [X_W-1:0]         ship_next;
  logic [CD_W-1:0]        cooldown;
  logic                   fire_accept;
  logic [NUM_BULLETS-1:0] load_vec;

  // A shot is possible when the cooldown has expired and a slot is free.
  assign o_fire_ready = (cooldown == '0) && !(&o_bullet_active);
  assign fire_accept  = i_shoot && o_fire_ready;

  // Lowest-index free slot gets the shot, based on start-of-cycle occupancy.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    logic found;
    load_vec = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_BULLETS; k++) begin
      if (!o_bullet_active[k] && !found) begin
        load_vec[k] = fire_accept;
        found       = 1'b1;
      end
    end
  end

  // Next ship column from the resolved move request.
  always_comb begin
    ship_next = o_ship_x;
    unique case (decode_move(i_left, i_right))
`ifdef PLAYER_MULTISHOT_WRAP_EN
      MOVE_LEFT:  ship_next = o_ship_x - X_W'(1);
      MOVE_RIGHT: ship_next = o_ship_x + X_W'(1);
`else
      MOVE_LEFT:  if (o_ship_x != '0)   ship_next = o_ship_x - X_W'(1);
      MOVE_RIGHT: if (o_ship_x != X_MAX) ship_next = o_ship_x + X_W'(1);
`endif
      default:    ship_next = o_ship_x;
    endcase
  end

  // Ship column register.
  always_ff @(posedge i_clk_36MHz) begin
    if (i_reset) o_ship_x <= X_W'(SHIP_X_RST);
    else         o_ship_x <= ship_next;
  end

  // Fire cooldown: reload on an accepted shot, otherwise count down on tick.
  always_ff @(posedge i_clk_36MHz) begin
    if (i_reset)                       cooldown <= '0;
    else if (fire_accept)              cooldown <= CD_W'(COOLDOWN);
    else if (i_tick && cooldown != '0) cooldown <= cooldown - CD_W'(1);
  end

  // Bullet slots; a new bullet takes the pre-move ship column.
  for (genvar k = 0; k < NUM_BULLETS; k++) begin : g_slot
    bullet_slot #(
      .X_W (X_W),
      .Y_W (Y_W)
    ) u_slot (
      .clk    (i_clk_36MHz),
      .reset  (i_reset),
      .load   (load_vec[k]),
      .load_x (o_ship_x),
      .tick   (i_tick),
      .hit    (i_hit[k]),
      .active (o_bullet_active[k]),
      .x      (o_bullet_x[k*X_W +: X_W]),
      .y      (o_bullet_y[k*Y_W +: Y_W])
    );
  end

endmodule

// File: tb/tb_player_multishot.sv
// Self-checking bench for player_multishot: directed vector table, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_player_multishot;

  localparam int X_W      = 5;
  localparam int Y_W      = 4;
  localparam int NB       = 4;
  localparam int CD       = 2;
  localparam int SHIP_RST = 16;
  localparam int X_MAX    = 31;
  localparam int Y_MAX    = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset = 1'b0, left = 1'b0, right = 1'b0;
  logic                shoot = 1'b0, tick = 1'b0;
  logic [NB-1:0]       hit = '0;
  logic [X_W-1:0]      ship_x;
  logic [NB-1:0]       b_active;
  logic [NB*X_W-1:0]   b_x;
  logic [NB*Y_W-1:0]   b_y;
  logic                fire_ready;

  player_multishot #(
    .X_W(X_W), .Y_W(Y_W), .NUM_BULLETS(NB), .COOLDOWN(CD), .SHIP_X_RST(SHIP_RST)
  ) dut (
    .i_clk_36MHz     (clk),
    .i_reset         (reset),
    .i_left          (left),
    .i_right         (right),
    .i_shoot         (shoot),
    .i_tick          (tick),
    .i_hit           (hit),
    .o_ship_x        (ship_x),
    .o_bullet_active (b_active),
    .o_bullet_x      (b_x),
    .o_bullet_y      (b_y),
    .o_fire_ready    (fire_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  int m_ship;
  int m_cd;
  bit m_act [NB];
  int m_x   [NB];
  int m_y   [NB];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock given this cycle's inputs.
  task automatic model_step(input bit rst, input bit l, input bit r, input bit s,
                            input bit t, input bit [NB-1:0] h);
    int free;
    bit fire;
    int old_ship;
    if (rst) begin
      m_ship = SHIP_RST;
      m_cd   = 0;
      for (int k = 0; k < NB; k++) begin
        m_act[k] = 0; m_x[k] = 0; m_y[k] = Y_MAX;
      end
      return;
    end
    free = -1;
    for (int k = 0; k < NB; k++) if (!m_act[k] && free < 0) free = k;
    fire     = s && (m_cd == 0) && (free >= 0);
    old_ship = m_ship;
`ifdef PLAYER_MULTISHOT_WRAP_EN
    if (l && !r) m_ship = (m_ship == 0) ? X_MAX : m_ship - 1;
    if (r && !l) m_ship = (m_ship == X_MAX) ? 0 : m_ship + 1;
`else
    if (l && !r && m_ship > 0)     m_ship = m_ship - 1;
    if (r && !l && m_ship < X_MAX) m_ship = m_ship + 1;
`endif
    for (int k = 0; k < NB; k++) begin
      if (m_act[k]) begin
        if (h[k] || (t && m_y[k] == 0)) begin
          m_act[k] = 0; m_x[k] = 0; m_y[k] = Y_MAX;
        end else if (t) begin
          m_y[k] = m_y[k] - 1;
        end
      end
    end
    if (fire) begin
      m_act[free] = 1; m_x[free] = old_ship; m_y[free] = Y_MAX - 1;
      m_cd = CD;
    end else if (t && m_cd > 0) begin
      m_cd = m_cd - 1;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [NB-1:0]     e_act;
    logic [NB*X_W-1:0] e_x;
    logic [NB*Y_W-1:0] e_y;
    bit                any_free;
    any_free = 0;
    for (int k = 0; k < NB; k++) begin
      e_act[k]             = m_act[k];
      e_x[k*X_W +: X_W]    = X_W'(m_x[k]);
      e_y[k*Y_W +: Y_W]    = Y_W'(m_y[k]);
      if (!m_act[k]) any_free = 1;
    end
    check({tag, "_ship"},   64'(ship_x),     64'(m_ship));
    check({tag, "_active"}, 64'(b_active),   64'(e_act));
    check({tag, "_x"},      64'(b_x),        64'(e_x));
    check({tag, "_y"},      64'(b_y),        64'(e_y));
    check({tag, "_ready"},  64'(fire_ready), 64'((m_cd == 0) && any_free));
  endtask

  // Drive one cycle of inputs, step the model, then sample after the edge.
  task automatic step(input bit rst, input bit l, input bit r, input bit s,
                      input bit t, input bit [NB-1:0] h, input string tag);
    reset = rst; left = l; right = r; shoot = s; tick = t; hit = h;
    model_step(rst, l, r, s, t, h);
    @(posedge clk);
    #1;
    reset = 0; left = 0; right = 0; shoot = 0; tick = 0; hit = '0;
    compare_all(tag);
  endtask

  typedef struct {
    bit       l, r, s, t;
    bit [3:0] h;
    int       exp_ship;
    bit [3:0] exp_act;
    bit       exp_ready;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Directed table starting from reset (ship 16, cooldown 2).
    tbl[0]  = '{0,1,0,0, 4'b0000, 17, 4'b0000, 1};
    tbl[1]  = '{0,1,0,0, 4'b0000, 18, 4'b0000, 1};
    tbl[2]  = '{0,1,0,0, 4'b0000, 19, 4'b0000, 1};
    tbl[3]  = '{0,0,1,0, 4'b0000, 19, 4'b0001, 0};
    tbl[4]  = '{0,0,1,0, 4'b0000, 19, 4'b0001, 0};
    tbl[5]  = '{0,0,0,1, 4'b0000, 19, 4'b0001, 0};
    tbl[6]  = '{0,0,0,1, 4'b0000, 19, 4'b0001, 1};
    tbl[7]  = '{1,0,1,0, 4'b0000, 18, 4'b0011, 0};
    tbl[8]  = '{1,1,0,0, 4'b0000, 18, 4'b0011, 0};
    tbl[9]  = '{0,0,0,0, 4'b0001, 18, 4'b0010, 0};
    tbl[10] = '{0,0,0,0, 4'b0100, 18, 4'b0010, 0};

    step(1, 0, 0, 0, 0, '0, "reset");
    check("reset_ship", 64'(ship_x), 64'(16));
    check("reset_y",    64'(b_y),    64'hFFFF);
    for (int i = 0; i < 11; i++) begin
      step(0, tbl[i].l, tbl[i].r, tbl[i].s, tbl[i].t, tbl[i].h, "tbl");
      check("tbl_ship_c",  64'(ship_x),     64'(tbl[i].exp_ship));
      check("tbl_act_c",   64'(b_active),   64'(tbl[i].exp_act));
      check("tbl_ready_c", 64'(fire_ready), 64'(tbl[i].exp_ready));
    end
    check("tbl_slot1_x", 64'(b_x[9:5]), 64'(19));

    // Right edge: 15 rights reach 31, one more saturates (or wraps).
    step(1, 0, 0, 0, 0, '0, "edge_rst");
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0, '0, "edge");
    check("edge_at_max", 64'(ship_x), 64'(31));
    step(0, 0, 1, 0, 0, '0, "edge");
`ifdef PLAYER_MULTISHOT_WRAP_EN
    check("edge_wrap", 64'(ship_x), 64'(0));
`else
    check("edge_hold", 64'(ship_x), 64'(31));
`endif
    for (int i = 0; i < 33; i++) step(0, 1, 0, 0, 0, '0, "edge_l");

    // Bullet flight: 14 ticks count y down to 0, the 15th retires it.
    step(1, 0, 0, 0, 0, '0, "fly_rst");
    step(0, 0, 0, 1, 1, '0, "fly");
    check("fly_y0", 64'(b_y[3:0]), 64'(14));
    for (int i = 1; i <= 14; i++) begin
      step(0, 0, 0, 0, 1, '0, "fly");
      check("fly_y", 64'(b_y[3:0]), 64'(14 - i));
    end
    step(0, 0, 0, 0, 1, '0, "fly");
    check("fly_gone_act", 64'(b_active), 64'(0));
    check("fly_gone_y",   64'(b_y[3:0]), 64'(15));

    // Fill all slots at ship column 10, then hit+shoot collision.
    step(1, 0, 0, 0, 0, '0, "fill_rst");
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, '0, "fill_mv");
    step(0, 0, 0, 1, 0, '0, "fill");
    check("fill_s0_x", 64'(b_x[4:0]), 64'(10));
    check("fill_s0_y", 64'(b_y[3:0]), 64'(14));
    for (int n = 0; n < 3; n++) begin
      step(0, 0, 0, 0, 1, '0, "fill");
      step(0, 0, 0, 0, 1, '0, "fill");
      step(0, 0, 0, 1, 0, '0, "fill");
    end
    check("fill_all", 64'(b_active), 64'hF);
    step(0, 0, 0, 0, 1, '0, "fill");
    step(0, 0, 0, 0, 1, '0, "fill");
    check("fill_full_ready", 64'(fire_ready), 64'(0));
    step(0, 0, 0, 1, 0, '0, "fill_drop");
    check("fill_drop_act", 64'(b_active), 64'hF);
    step(0, 0, 0, 1, 0, 4'b0100, "hit_shoot");
    check("hit_shoot_act",   64'(b_active),   64'hB);
    check("hit_shoot_ready", 64'(fire_ready), 64'(1));
    step(0, 0, 0, 1, 0, '0, "realloc");
    check("realloc_act", 64'(b_active), 64'hF);

    // Reset in the middle of play.
    step(1, 0, 0, 0, 0, '0, "mid_rst0");
    step(0, 0, 0, 1, 0, '0, "mid");
    step(0, 0, 0, 0, 1, '0, "mid");
    step(0, 0, 0, 0, 1, '0, "mid");
    step(0, 0, 0, 1, 0, '0, "mid");
    step(0, 0, 0, 0, 1, '0, "mid");
    step(0, 0, 0, 0, 1, '0, "mid");
    step(0, 0, 0, 1, 0, '0, "mid");
    step(0, 0, 0, 0, 1, '0, "mid");
    check("mid_act",   64'(b_active),   64'h7);
    check("mid_ready", 64'(fire_ready), 64'(0));
    step(1, 1, 0, 1, 1, 4'b1111, "mid_rst");
    check("mid_rst_ship",  64'(ship_x),     64'(16));
    check("mid_rst_act",   64'(b_active),   64'(0));
    check("mid_rst_ready", 64'(fire_ready), 64'(1));
    check("mid_rst_x",     64'(b_x),        64'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit [NB-1:0] h;
      for (int k = 0; k < NB; k++) h[k] = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 0,
           $urandom_range(0, 2) == 0,
           h, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
